// File: rtl/shift_sub_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/stop
// handshake shared with the shift-and-add multiplier.
module shift_sub_div #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_stop,
  output logic         o_busy,
  output logic         o_div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(N + 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          dbz_q, dbz_d;

  logic [N+1:0]  shifted;
  logic [N+1:0]  trial;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;

  // Trial subtraction is one bit wider than the shifted remainder, so its
  // top bit is the borrow: set means the divisor did not fit this step.
  always_comb begin
    shifted  = {rem_q, quo_q[N-1]};
    trial    = shifted - {2'b00, div_q};
    rem_next = trial[N+1] ? shifted[N:0] : trial[N:0];
    quo_next = {quo_q[N-2:0], ~trial[N+1]};
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_divisor != '0) begin
            state_d = S_CALC;
            div_d   = i_divisor;
            quo_d   = i_dividend;
            rem_d   = '0;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            quot_d  = '1;
            rmd_d   = i_dividend;
            dbz_d   = 1'b1;
            stop_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          quot_d  = quo_next;
          rmd_d   = rem_next[N-1:0];
          stop_d  = 1'b1;
          busy_d  = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (!i_start) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_quotient    = quot_q;
  assign o_remainder   = rmd_q;
  assign o_stop        = stop_q;
  assign o_busy        = busy_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// Self-checking bench for shift_sub_div (N=8): directed cases plus a random
// sweep compared against plain / and % arithmetic.
module tb_shift_sub_div;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_dividend;
  logic [7:0] i_divisor;
  logic [7:0] o_quotient;
  logic [7:0] o_remainder;
  logic       o_stop;
  logic       o_busy;
  logic       o_div_by_zero;

  int n_cmp;
  int n_bad;

  shift_sub_div #(.N(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_stop       (o_stop),
    .o_busy       (o_busy),
    .o_div_by_zero(o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drops start for one edge (returns DONE to IDLE), then requests dd/dv and
  // counts edges up to and including the one that raises o_stop (bounded).
  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv, input bit scramble,
                         output int edges, output int busy_cyc, output bit overlap);
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_dividend = dd;
    i_divisor  = dv;
    i_start    = 1'b1;
    edges = 0;
    busy_cyc = 0;
    overlap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      edges++;
      if (o_busy) busy_cyc++;
      if (o_busy && o_stop) overlap = 1'b1;
      if (scramble && edges == 1) begin
        i_dividend = 8'($urandom);
        i_divisor  = 8'($urandom);
      end
      if (o_stop) break;
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_quotient, o_remainder, o_stop, o_busy, o_div_by_zero} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got q=%h r=%h stop=%b busy=%b dbz=%b, want all 0",
               o_quotient, o_remainder, o_stop, o_busy, o_div_by_zero);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_basic_hold;
    int e, b;
    bit ov;
    run_div(8'd200, 8'd7, 1'b0, e, b, ov);
    n_cmp++;
    if (e !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d edges, want 9", e); end
    n_cmp++;
    if (b !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d, want 8", b); end
    n_cmp++;
    if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_busy_stop_overlap: got 1, want 0"); end
    n_cmp++;
    if ({o_quotient, o_remainder, o_div_by_zero} !== {8'd28, 8'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0",
               o_quotient, o_remainder, o_div_by_zero);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      n_cmp++;
      if ({o_stop, o_busy, o_quotient, o_remainder} !== {1'b1, 1'b0, 8'd28, 8'd4}) begin
        n_bad++;
        $display("FAIL hold_no_retrigger: got stop=%b busy=%b q=%0d r=%0d, want 1 0 28 4",
                 o_stop, o_busy, o_quotient, o_remainder);
      end
    end
    i_start = 1'b0;
    @(posedge i_clk); #1;
    n_cmp++;
    if ({o_stop, o_busy, o_quotient, o_remainder} !== {1'b0, 1'b0, 8'd28, 8'd4}) begin
      n_bad++;
      $display("FAIL release_start: got stop=%b busy=%b q=%0d r=%0d, want 0 0 28 4",
               o_stop, o_busy, o_quotient, o_remainder);
    end
  endtask

  task automatic test_directed;
    logic [7:0] dd_t [4] = '{8'h31, 8'hFF, 8'd5, 8'd0};
    logic [7:0] dv_t [4] = '{8'h12, 8'h01, 8'd9, 8'd3};
    logic [7:0] q_t  [4] = '{8'h02, 8'hFF, 8'd0, 8'd0};
    logic [7:0] r_t  [4] = '{8'h0D, 8'h00, 8'd5, 8'd0};
    int e, b;
    bit ov;
    for (int k = 0; k < 4; k++) begin
      run_div(dd_t[k], dv_t[k], 1'b0, e, b, ov);
      n_cmp++;
      if ({o_quotient, o_remainder, o_div_by_zero, e} !== {q_t[k], r_t[k], 1'b0, 32'd9}) begin
        n_bad++;
        $display("FAIL directed_%0d: %h/%h got q=%h r=%h dbz=%b edges=%0d, want q=%h r=%h dbz=0 edges=9",
                 k, dd_t[k], dv_t[k], o_quotient, o_remainder, o_div_by_zero, e, q_t[k], r_t[k]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int e, b;
    bit ov;
    run_div(8'h55, 8'h00, 1'b0, e, b, ov);
    n_cmp++;
    if ({o_quotient, o_remainder, o_div_by_zero, o_busy, e, b} !==
        {8'hFF, 8'h55, 1'b1, 1'b0, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL div_by_zero: got q=%h r=%h dbz=%b busy=%b edges=%0d busy_cyc=%0d, want FF 55 1 0 1 0",
               o_quotient, o_remainder, o_div_by_zero, o_busy, e, b);
    end
    // A later normal result must clear the flag.
    run_div(8'd9, 8'd2, 1'b0, e, b, ov);
    n_cmp++;
    if ({o_quotient, o_remainder, o_div_by_zero} !== {8'd4, 8'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL dbz_clears: got q=%0d r=%0d dbz=%b, want 4 1 0",
               o_quotient, o_remainder, o_div_by_zero);
    end
  endtask

  task automatic test_reset_mid_calc;
    int e, b;
    bit ov;
    bit seen;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_dividend = 8'd100;
    i_divisor  = 8'd3;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++;
    if ({o_quotient, o_remainder, o_stop, o_busy, o_div_by_zero} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_mid_calc: got q=%h r=%h stop=%b busy=%b dbz=%b, want all 0",
               o_quotient, o_remainder, o_stop, o_busy, o_div_by_zero);
    end
    i_rst = 1'b0;
    i_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk); #1;
      if (o_stop || o_busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL aborted_stays_idle: got activity=1, want 0"); end
    run_div(8'd100, 8'd3, 1'b0, e, b, ov);
    n_cmp++;
    if ({o_quotient, o_remainder, e} !== {8'd33, 8'd1, 32'd9}) begin
      n_bad++;
      $display("FAIL restart_after_reset: got q=%0d r=%0d edges=%0d, want 33 1 9",
               o_quotient, o_remainder, e);
    end
  endtask

  task automatic test_operand_change;
    int e, b;
    bit ov;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] dd, dv;
      dd = 8'($urandom);
      dv = 8'($urandom_range(1, 255));
      run_div(dd, dv, 1'b1, e, b, ov);
      n_cmp++;
      if ({o_quotient, o_remainder, e} !== {8'(dd / dv), 8'(dd % dv), 32'd9}) begin
        n_bad++;
        $display("FAIL operand_change_%0d: %0d/%0d got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=9",
                 k, dd, dv, o_quotient, o_remainder, e, dd / dv, dd % dv);
      end
    end
  endtask

  task automatic test_random;
    int e, b;
    bit ov;
    for (int k = 0; k < 1000; k++) begin
      logic [7:0] dd, dv, eq, er;
      bit edbz;
      int elat;
      dd = 8'($urandom);
      dv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (dv == 0) begin eq = 8'hFF; er = dd; edbz = 1'b1; elat = 1; end
      else begin eq = 8'(dd / dv); er = 8'(dd % dv); edbz = 1'b0; elat = 9; end
      run_div(dd, dv, 1'b0, e, b, ov);
      n_cmp++;
      if ({o_quotient, o_remainder, o_div_by_zero, e, ov} !== {eq, er, edbz, elat, 1'b0}) begin
        n_bad++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b edges=%0d ovl=%b, want q=%0d r=%0d dbz=%b edges=%0d ovl=0",
                 k, dd, dv, o_quotient, o_remainder, o_div_by_zero, e, ov, eq, er, edbz, elat);
      end
      if (dv != 0) begin
        n_cmp++;
        if (!((int'(o_quotient) * int'(dv) + int'(o_remainder) == int'(dd)) && (o_remainder < dv))) begin
          n_bad++;
          $display("FAIL invariant_%0d: %0d/%0d got q=%0d r=%0d, want q*d+r=dividend and r<d",
                   k, dd, dv, o_quotient, o_remainder);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_hold();
    test_directed();
    test_div_by_zero();
    test_reset_mid_calc();
    test_operand_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
